four_operand_sequencer: RTL and testbench
=========================================

Name: four_operand_sequencer

Overview:
- Initiator-side companion to the four-input adder.
- Accepts a serial stream of operand words over a valid/ready handshake and packs them into groups of four.
- Issues each group to the adder with a one-cycle en pulse, captures the registered sum and overflow on the adder's vld pulse, and returns them over a valid/ready result handshake.
- Sits between an operand source (FIFO or bus) and the adder datapath.

Parameters:
_W, 32, operand/sum width; must match the attached adder's _W
_CW, 16, width of the completed-group counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_vld  input  1  operand word valid
in_rdy  output  1  sequencer can accept operand word
in_data  input  _W  operand word
flush  input  1  synchronous; discard partially collected group
add_en  output  1  one-cycle issue pulse to adder en
add_a0  output  _W  operand 0 (first word of group)
add_a1  output  _W  operand 1
add_a2  output  _W  operand 2
add_a3  output  _W  operand 3 (last word of group)
add_b  input  _W  adder registered sum
add_of  input  1  adder registered overflow flag
add_vld  input  1  adder result valid pulse, one cycle after add_en
out_vld  output  1  result valid
out_rdy  input  1  downstream accepts result
out_sum  output  _W  captured sum
out_of  output  1  captured overflow
grp_cnt  output  _CW  number of results accepted downstream, wraps modulo 2^_CW
err  output  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): state=COLLECT, word index=0, in_rdy=0 while rst asserted, add_en=0, add_a0..a3=0, out_vld=0, out_sum=0, out_of=0, grp_cnt=0, err=0.
- COLLECT:
  - in_rdy=1.
  - On in_vld&in_rdy, in_data is written to operand register [index] and index increments.
  - When the 4th word (index 3) is accepted, index returns to 0 and the next state is ISSUE.
- ISSUE:
  - Lasts exactly one cycle; add_en=1 and in_rdy=0; next state WAIT.
  - add_a0..a3 are registered and stable from the cycle of add_en until the group's result is captured.
- WAIT:
  - in_rdy=0.
  - On add_vld: out_sum<=add_b, out_of<=add_of, out_vld<=1, next state HOLD.
  - Nominal latency: add_vld arrives the cycle after add_en; no timeout is implemented.
- HOLD:
  - out_vld=1, and out_sum/out_of are stable until out_vld&out_rdy.
  - On the handshake: out_vld<=0, grp_cnt increments, next state COLLECT.
  - in_rdy=0 in HOLD. There is no overlap of the next group's collection with result hold; throughput is at most one group per 7 cycles with no backpressure.
- Overall latency: 4th operand accepted at cycle t -> add_en at t+1 -> add_vld at t+2 -> out_vld=1 from t+3.
- flush:
  - In COLLECT, resets index to 0 and discards the collected words; operand registers need not be cleared.
  - Words presented in the flush cycle are not accepted (in_rdy=0 while flush=1).
  - In ISSUE/WAIT/HOLD, flush is ignored; an in-flight group always completes.
- err is set sticky (cleared only by rst) when:
  - add_vld=1 in any state other than WAIT, or
  - in_vld is held but in_data changes while in_rdy=0. This is optional in RTL; the bench checks only the add_vld case.
- Arithmetic: no arithmetic is performed here; widths pass through unchanged. grp_cnt wraps from 2^_CW-1 to 0 silently.
- Reset mid-operation: returns to COLLECT with all outputs at reset values; any in-flight adder result arriving after reset release while in COLLECT sets err.

Decomposition:
- Shared package four_adder_pkg holds:
  - the state enum seq_state_t {COLLECT, ISSUE, WAIT, HOLD}, 2-bit;
  - the constant N_OPS=4;
  - the index width localparam IDX_W=2.
- One sub-module is natural: operand_bank, a 4x_W register file with write-enable and 2-bit write index. It is instantiated once.
- Output registers use the existing d_register/d_ff primitives.

Test Plan:
- Basic: feed 1,2,3,4 back-to-back with an adder model -> one add_en pulse, add_a0..a3=1,2,3,4, out_sum=10, out_of=0, out_vld exactly 3 cycles after the 4th word, grp_cnt=1.
- Overflow, _W=32: feed 0xFFFFFFFF,1,0,0 -> out_sum=0x00000000, out_of=1.
- Backpressure: out_rdy=0 for 10 cycles after out_vld -> out_sum/out_of stable and in_rdy=0 throughout; accept on cycle 11 -> grp_cnt increments once and in_rdy=1 next cycle.
- Flush: feed 5,6, assert flush, then feed 7,8,9,10 -> add_a0..a3=7,8,9,10, out_sum=34; 5 and 6 are never issued.
- Protocol error: inject add_vld while in COLLECT -> err=1 and stays 1 through later normal groups until rst.
- Reset mid-WAIT: assert rst the cycle after add_en -> out_vld=0, grp_cnt=0, in_rdy=1 the first cycle after release; a late add_vld then sets err=1.

Source files
------------

// File: rtl/four_operand_sequencer_pkg.sv
// Shared types and constants for the four-operand adder datapath.
package four_adder_pkg;
  localparam int N_OPS = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } seq_state_t;
endpackage

// File: rtl/four_operand_sequencer_if.sv
// Operand stream, adder issue/result and result stream bundle.
interface four_operand_sequencer_if #(
  parameter int _W  = 32,
  parameter int _CW = 16
);
  logic           in_vld;
  logic           in_rdy;
  logic [_W-1:0]  in_data;
  logic           flush;
  logic           add_en;
  logic [_W-1:0]  add_a0;
  logic [_W-1:0]  add_a1;
  logic [_W-1:0]  add_a2;
  logic [_W-1:0]  add_a3;
  logic [_W-1:0]  add_b;
  logic           add_of;
  logic           add_vld;
  logic           out_vld;
  logic           out_rdy;
  logic [_W-1:0]  out_sum;
  logic           out_of;
  logic [_CW-1:0] grp_cnt;
  logic           err;

  // Sequencer side.
  modport master (
    input  in_vld, in_data, flush, add_b, add_of, add_vld, out_rdy,
    output in_rdy, add_en, add_a0, add_a1, add_a2, add_a3,
           out_vld, out_sum, out_of, grp_cnt, err
  );

  // Source / adder / sink side.
  modport slave (
    output in_vld, in_data, flush, add_b, add_of, add_vld, out_rdy,
    input  in_rdy, add_en, add_a0, add_a1, add_a2, add_a3,
           out_vld, out_sum, out_of, grp_cnt, err
  );
endinterface

// File: rtl/four_operand_sequencer_operand_bank.sv
// Four-entry operand register file, one slot written per accepted word.
module operand_bank
  import four_adder_pkg::*;
#(
  parameter int _W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            idx_i,
  input  logic [_W-1:0]               wdata_i,
  output logic [N_OPS-1:0][_W-1:0]    rdata_o
);
  logic [N_OPS-1:0][_W-1:0] regs_q;

  for (genvar i = 0; i < N_OPS; i++) begin : g_slot
    // Slot i captures the incoming word when it is the addressed slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 regs_q[i] <= '0;
      else if (we_i && (idx_i == IDX_W'(i)))   regs_q[i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q;
endmodule

// File: rtl/four_operand_sequencer.sv
// Packs a serial operand stream into groups of four, issues each group to the
// four-input adder and returns the captured sum/overflow over a handshake.
module four_operand_sequencer
  import four_adder_pkg::*;
#(
  parameter int _W  = 32,
  parameter int _CW = 16
) (
  input logic                      clk,
  input logic                      rst,
  four_operand_sequencer_if.master bus
);
  seq_state_t               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     out_vld_q, out_vld_d;
  logic [_W-1:0]            out_sum_q, out_sum_d;
  logic                     out_of_q, out_of_d;
  logic [_CW-1:0]           grp_cnt_q, grp_cnt_d;
  logic                     err_q, err_d;
  logic                     rdy, accept;
  logic [N_OPS-1:0][_W-1:0] ops;

  // Words are refused during reset and in the flush cycle.
  assign rdy    = (state_q == COLLECT) && !bus.flush && !rst;
  assign accept = bus.in_vld && rdy;

  operand_bank #(._W(_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (accept),
    .idx_i   (idx_q),
    .wdata_i (bus.in_data),
    .rdata_o (ops)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      out_vld_q <= 1'b0;
      out_sum_q <= '0;
      out_of_q  <= 1'b0;
      grp_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_vld_q <= out_vld_d;
      out_sum_q <= out_sum_d;
      out_of_q  <= out_of_d;
      grp_cnt_q <= grp_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state: collect four words, issue, wait for sum, hold until taken.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_vld_d = out_vld_q;
    out_sum_d = out_sum_q;
    out_of_d  = out_of_q;
    grp_cnt_d = grp_cnt_q;
    // A result pulse outside WAIT has no group to belong to.
    err_d     = err_q | (bus.add_vld && (state_q != WAIT));
    unique case (state_q)
      COLLECT: begin
        if (bus.flush) begin
          idx_d = '0;
        end else if (accept) begin
          idx_d = idx_q + IDX_W'(1);  // wraps to 0 after the last slot
          if (idx_q == IDX_W'(N_OPS - 1)) state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.add_vld) begin
          out_sum_d = bus.add_b;
          out_of_d  = bus.add_of;
          out_vld_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_vld_q && bus.out_rdy) begin
          out_vld_d = 1'b0;
          grp_cnt_d = grp_cnt_q + _CW'(1);
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.in_rdy  = rdy;
  assign bus.add_en  = (state_q == ISSUE);
  assign bus.add_a0  = ops[0];
  assign bus.add_a1  = ops[1];
  assign bus.add_a2  = ops[2];
  assign bus.add_a3  = ops[3];
  assign bus.out_vld = out_vld_q;
  assign bus.out_sum = out_sum_q;
  assign bus.out_of  = out_of_q;
  assign bus.grp_cnt = grp_cnt_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_four_operand_sequencer.sv
// Scoreboard bench: stimulus feeds words, a reference model builds expected
// groups, a negedge monitor compares everything the sequencer presents.
module tb_four_operand_sequencer;
  localparam int W  = 32;
  localparam int CW = 3;  // small so the group counter wraps

  typedef struct packed {
    logic [3:0][W-1:0] a;
    logic [W-1:0]      s;
    logic              o;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  four_operand_sequencer_if #(._W(W), ._CW(CW)) bus ();
  four_operand_sequencer #(._W(W), ._CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- adder stand-in ----------------
  logic hold_resp = 1'b0;
  int   rdy_mode  = 0;   // 0 always ready, 1 random, 2 stalled
  int   inj_cnt   = 0;

  initial begin
    logic         pend;
    logic [W+1:0] tot;
    logic [W-1:0] psum;
    logic         pof;
    int           inj_done;
    pend = 0; inj_done = 0; psum = '0; pof = 0;
    bus.add_vld = 0; bus.add_b = '0; bus.add_of = 0;
    forever begin
      @(posedge clk); #1;
      bus.add_vld = 0;
      if (pend && !hold_resp) begin
        bus.add_vld = 1; bus.add_b = psum; bus.add_of = pof; pend = 0;
      end else if (inj_cnt != inj_done) begin
        bus.add_vld = 1; bus.add_b = '1; bus.add_of = 0; inj_done++;
      end
      if (bus.add_en) begin
        tot  = (W+2)'(bus.add_a0) + (W+2)'(bus.add_a1) + (W+2)'(bus.add_a2) + (W+2)'(bus.add_a3);
        psum = tot[W-1:0];
        pof  = |tot[W+1:W];
        pend = 1;
      end
    end
  end

  // ---------------- downstream ready ----------------
  initial begin
    bus.out_rdy = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_rdy = 1;
        1:       bus.out_rdy = 1'($urandom_range(0, 1));
        default: bus.out_rdy = 0;
      endcase
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [W-1:0]  partial[$];
  grp_t          iss_q[$];
  grp_t          res_q[$];
  logic          collecting = 1;
  logic          err_exp    = 0;
  logic [CW-1:0] grp_exp    = '0;
  int            cyc = 0, issue_due = -1, vld_due = -1;
  logic          prev_vld = 0, prev_hs = 0, prev_of = 0;
  logic [W-1:0]  prev_sum = '0;

  always @(negedge clk) begin
    grp_t         g;
    logic [W+1:0] tot;
    logic         rdy_exp, coll_old;
    cyc++;
    if (rst) begin
      chk("rst_in_rdy",  64'(bus.in_rdy), 0);
      chk("rst_add_en",  64'(bus.add_en), 0);
      chk("rst_out_vld", 64'(bus.out_vld), 0);
      chk("rst_grp_cnt", 64'(bus.grp_cnt), 0);
      chk("rst_err",     64'(bus.err), 0);
      partial.delete(); iss_q.delete(); res_q.delete();
      collecting = 1; err_exp = 0; grp_exp = '0; prev_vld = 0; prev_hs = 0;
    end else begin
      coll_old = collecting;
      rdy_exp  = collecting && !bus.flush;
      chk("err",     64'(bus.err), 64'(err_exp));
      chk("grp_cnt", 64'(bus.grp_cnt), 64'(grp_exp));
      chk("in_rdy",  64'(bus.in_rdy), 64'(rdy_exp));
      if (bus.add_vld && collecting) err_exp = 1;
      if (bus.add_en) begin
        chk("issue_latency", 64'(cyc), 64'(issue_due));
        if (iss_q.size() == 0) chk("issue_unexpected", 64'(iss_q.size()), 1);
        else begin
          g = iss_q.pop_front();
          chk("add_a0", 64'(bus.add_a0), 64'(g.a[0]));
          chk("add_a1", 64'(bus.add_a1), 64'(g.a[1]));
          chk("add_a2", 64'(bus.add_a2), 64'(g.a[2]));
          chk("add_a3", 64'(bus.add_a3), 64'(g.a[3]));
        end
      end
      if (bus.out_vld && !prev_vld) chk("out_vld_latency", 64'(cyc), 64'(vld_due));
      if (bus.out_vld && prev_vld && !prev_hs) begin
        chk("hold_sum_stable", 64'(bus.out_sum), 64'(prev_sum));
        chk("hold_of_stable",  64'(bus.out_of), 64'(prev_of));
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (res_q.size() == 0) chk("result_unexpected", 64'(res_q.size()), 1);
        else begin
          g = res_q.pop_front();
          chk("out_sum", 64'(bus.out_sum), 64'(g.s));
          chk("out_of",  64'(bus.out_of), 64'(g.o));
        end
        grp_exp++;
        collecting = 1;
      end
      if (bus.in_vld && rdy_exp) begin
        partial.push_back(bus.in_data);
        if (partial.size() == 4) begin
          tot = '0;
          for (int i = 0; i < 4; i++) begin
            g.a[i] = partial[i];
            tot    = tot + (W+2)'(partial[i]);
          end
          g.s = tot[W-1:0];
          g.o = |tot[W+1:W];
          iss_q.push_back(g);
          res_q.push_back(g);
          partial.delete();
          collecting = 0;
          issue_due  = cyc + 1;
          vld_due    = cyc + 3;
        end
      end
      if (bus.flush && coll_old) partial.delete();
      prev_vld = bus.out_vld;
      prev_sum = bus.out_sum;
      prev_of  = bus.out_of;
      prev_hs  = bus.out_vld && bus.out_rdy;
    end
  end

  // ---------------- stimulus ----------------
  // Called aligned just after a rising edge; returns aligned the same way.
  task automatic send(input logic [W-1:0] w);
    logic acc;
    int   n;
    bus.in_vld = 1; bus.in_data = w; n = 0;
    do begin
      @(negedge clk); acc = bus.in_rdy;
      @(posedge clk); #1; n++;
    end while (!acc && n < 300);
    if (!acc) chk("send_timeout", 64'(acc), 1);
    bus.in_vld = 0;
  endtask

  task automatic wait_one_group();
    logic [CW-1:0] t;
    int n;
    t = grp_exp + CW'(1); n = 0;
    while (grp_exp != t && n < 300) begin @(negedge clk); n++; end
    if (grp_exp != t) chk("group_timeout", 64'(grp_exp), 64'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bus.in_vld = 0; bus.in_data = '0; bus.flush = 0;
    repeat (2) @(negedge clk);
    chk("rst_add_a0",  64'(bus.add_a0), 0);
    chk("rst_add_a3",  64'(bus.add_a3), 0);
    chk("rst_out_sum", 64'(bus.out_sum), 0);
    chk("rst_out_of",  64'(bus.out_of), 0);
    @(posedge clk); #1 rst = 0;

    // basic group
    send(1); send(2); send(3); send(4);
    wait_one_group();
    @(negedge clk); chk("basic_grp_cnt", 64'(bus.grp_cnt), 1);
    @(posedge clk); #1;

    // overflow
    send(32'hFFFF_FFFF); send(1); send(0); send(0);
    wait_one_group();

    // backpressure
    rdy_mode = 2;
    send($urandom); send($urandom); send($urandom); send($urandom);
    n = 0;
    while (!bus.out_vld && n < 50) begin @(negedge clk); n++; end
    chk("bp_out_vld", 64'(bus.out_vld), 1);
    repeat (10) @(posedge clk);
    #1 rdy_mode = 0;
    wait_one_group();

    // flush with a word presented in the flush cycle
    send(5); send(6);
    bus.flush = 1; bus.in_vld = 1; bus.in_data = 99;
    @(posedge clk); #1 bus.flush = 0; bus.in_vld = 0;
    send(7); send(8); send(9); send(10);
    wait_one_group();

    // stray result pulse while collecting
    inj_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("err_set", 64'(bus.err), 1);
    @(posedge clk); #1;
    send(11); send(12); send(13); send(14);
    wait_one_group();

    // randomized traffic with flushes and random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.flush = 1; @(posedge clk); #1 bus.flush = 0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      if ($urandom_range(0, 3) == 0) send(32'hFFFF_FFF0 + W'($urandom_range(0, 15)));
      else send($urandom);
    end
    repeat (4) @(negedge clk);
    n = 0;
    while ((res_q.size() != 0 || bus.out_vld) && n < 300) begin @(negedge clk); n++; end
    chk("drain", 64'(res_q.size()), 0);
    @(posedge clk); #1 rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1 bus.flush = 1; @(posedge clk); #1 bus.flush = 0;

    // reset the cycle after add_en, then a late result arrives
    hold_resp = 1;
    send(21); send(22); send(23); send(24);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.add_en && n < 20);
    chk("mid_add_en", 64'(bus.add_en), 1);
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_out_vld", 64'(bus.out_vld), 0);
    chk("post_rst_grp_cnt", 64'(bus.grp_cnt), 0);
    chk("post_rst_in_rdy",  64'(bus.in_rdy), 1);
    hold_resp = 0;
    repeat (3) @(negedge clk);
    chk("late_vld_err", 64'(bus.err), 1);
    @(posedge clk); #1;
    send(1); send(1); send(1); send(1);
    wait_one_group();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
